// File: rtl/stopwatch_display_n.sv
// BCD stopwatch: start/pause/clear buttons, prescaled tick and a registered seven-segment output.
// Defining STOPWATCH_LAP_HOLD_EN builds the lap-freeze feature on lapControl.
module stopwatch_display_n #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    sysclk,
  input  logic                    resetb,
  input  logic [1:0]              testmode,
  input  logic                    modeControl,
  input  logic                    clearControl,
  input  logic                    lapControl,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    running,
  output logic                    overflow
);

  localparam int            PW           = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] DIV_FULL_M1  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DIV_TENTH_M1 = PW'(CLK_DIV / 10 - 1);
  localparam logic [6:0]    SEG_ZERO     = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
  localparam logic [6:0]    SEG_ALL_LIT  = SEG_ACTIVE_LOW ? 7'b0000000 : 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic [NB-1:0]                 btn_raw, sync1_q, sync2_q, edge_q, btn_ev;
  logic                          ev_mode, ev_clear;
  state_e                        state_q, state_d;
  logic [PW-1:0]                 presc_q, presc_d, div_m1;
  logic [NUM_DIGITS-1:0][3:0]    digits_q, digits_d, shown;
  logic                          ovf_q, ovf_d, carry;
  logic [1:0]                    tm_q;
  logic [7*NUM_DIGITS-1:0]       hex_q, hex_d;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

`ifdef STOPWATCH_LAP_HOLD_EN
  assign btn_raw = {lapControl, clearControl, modeControl};
`else
  logic unused_lap;
  assign unused_lap = lapControl;
  assign btn_raw    = {clearControl, modeControl};
`endif

  // Event fires once: synchronised level high, previous synchronised level low.
  assign btn_ev   = sync2_q & ~edge_q;
  assign ev_mode  = btn_ev[0];
  assign ev_clear = btn_ev[1];

  always_comb begin
    unique case (testmode)
      2'b01:   div_m1 = DIV_TENTH_M1;
      2'b10:   div_m1 = '0;
      default: div_m1 = DIV_FULL_M1;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_d  = state_q;
    presc_d  = presc_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    carry    = 1'b0;

    if (testmode != tm_q) begin
      presc_d = '0;
    end else if (state_q == S_RUN) begin
      if (presc_q == div_m1) begin
        presc_d = '0;
        carry   = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (state_q == S_IDLE) begin
      presc_d = '0;
    end

    // The tick enters as carry into digit 0 and ripples up within the cycle.
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (digits_q[k] == 4'd9) begin
          digits_d[k] = 4'd0;
        end else begin
          digits_d[k] = digits_q[k] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry) ovf_d = 1'b1;

    unique case (state_q)
      S_IDLE:  if (ev_mode) state_d = S_RUN;
      S_RUN:   if (ev_mode) state_d = S_PAUSE;
      S_PAUSE: if (ev_mode) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (ev_clear) begin
      state_d  = S_IDLE;
      presc_d  = '0;
      digits_d = '0;
      ovf_d    = 1'b0;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic                       ev_lap, lap_on_q, lap_on_d;
  logic [NUM_DIGITS-1:0][3:0] lap_digits_q, lap_digits_d;

  assign ev_lap = btn_ev[2];

  always_comb begin
    lap_on_d     = lap_on_q;
    lap_digits_d = lap_digits_q;
    if (ev_clear) begin
      lap_on_d = 1'b0;
    end else if (ev_lap && state_q == S_RUN) begin
      lap_on_d = ~lap_on_q;
      if (!lap_on_q) lap_digits_d = digits_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!resetb) begin
      lap_on_q     <= 1'b0;
      lap_digits_q <= '0;
    end else begin
      lap_on_q     <= lap_on_d;
      lap_digits_q <= lap_digits_d;
    end
  end

  assign shown = lap_on_q ? lap_digits_q : digits_q;
`else
  assign shown = digits_q;
`endif

  always_comb begin
    hex_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      hex_d[7*k +: 7] = (testmode == 2'b11) ? SEG_ALL_LIT : seg_encode(shown[k]);
    end
  end

  // NOTE: resetb is only looked at on the rising edge; it is a synchronous reset.
  always_ff @(posedge sysclk) begin
    if (!resetb) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      state_q  <= S_IDLE;
      presc_q  <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      edge_q   <= '0;
      tm_q     <= testmode;
      hex_q    <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      edge_q   <= sync2_q;
      tm_q     <= testmode;
      hex_q    <= hex_d;
    end
  end

  assign hex      = hex_q;
  assign running  = (state_q == S_RUN);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_display_n.sv
// Bench for stopwatch_display_n (4 digits, CLK_DIV=20, active-low segments): directed
// vector table, multi-cycle corner sequences and a random phase against a decimal model.
module tb_stopwatch_display_n;

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic        sysclk = 1'b0;
  logic        resetb;
  logic [1:0]  testmode;
  logic        modeControl, clearControl, lapControl;
  logic [27:0] hex;
  logic        running, overflow;

  int checks = 0;
  int errors = 0;
  bit auto_chk = 1'b0;

  // Reference model: count held as a plain integer 0..9999.
  int          m_state = M_IDLE, m_count = 0, m_presc = 0, m_lap_val = 0;
  bit          m_ovf = 1'b0, m_lap_on = 1'b0;
  logic [1:0]  m_tm_prev = 2'b00;
  logic [27:0] m_hex = 28'h0;
  bit          hm[3], hc[3], hl[3];

  stopwatch_display_n #(
    .NUM_DIGITS    (4),
    .CLK_DIV       (20),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .sysclk      (sysclk),
    .resetb      (resetb),
    .testmode    (testmode),
    .modeControl (modeControl),
    .clearControl(clearControl),
    .lapControl  (lapControl),
    .hex         (hex),
    .running     (running),
    .overflow    (overflow)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [27:0] enc(input int v);
    logic [6:0]  tab [10];
    logic [27:0] h;
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    for (int k = 0; k < 4; k++) begin
      h[7*k +: 7] = tab[v % 10];
      v = v / 10;
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_hex"}, {4'h0, hex}, {4'h0, m_hex});
    check({tag, "_running"}, {31'd0, running}, {31'd0, m_state == M_RUN});
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  // Advance the model by the rules for one rising edge, using the inputs now applied.
  task automatic model_edge();
    bit ev_m, ev_c, ev_l;
    int div, old_count;
    if (!resetb) begin
      m_state = M_IDLE; m_count = 0; m_presc = 0; m_ovf = 1'b0;
      m_lap_on = 1'b0; m_lap_val = 0; m_hex = enc(0); m_tm_prev = testmode;
      for (int i = 0; i < 3; i++) begin hm[i] = 1'b0; hc[i] = 1'b0; hl[i] = 1'b0; end
    end else begin
      m_hex = (testmode == 2'b11) ? 28'h0 : enc(m_lap_on ? m_lap_val : m_count);
      ev_m = hm[1] && !hm[2];
      ev_c = hc[1] && !hc[2];
      ev_l = LAP_EN && hl[1] && !hl[2];
      div = (testmode == 2'b01) ? 2 : (testmode == 2'b10) ? 1 : 20;
      old_count = m_count;
      if (ev_c) begin
        m_state = M_IDLE; m_count = 0; m_presc = 0; m_ovf = 1'b0; m_lap_on = 1'b0;
      end else begin
        if (testmode != m_tm_prev) m_presc = 0;
        else if (m_state == M_RUN) begin
          if (m_presc == div - 1) begin
            m_presc = 0;
            m_count = m_count + 1;
            if (m_count == 10000) begin m_count = 0; m_ovf = 1'b1; end
          end else m_presc = m_presc + 1;
        end
        if (ev_l && m_state == M_RUN) begin
          if (!m_lap_on) m_lap_val = old_count;
          m_lap_on = !m_lap_on;
        end
        if (ev_m) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      end
      m_tm_prev = testmode;
      hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = modeControl;
      hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = clearControl;
      hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = lapControl;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge sysclk);
    @(negedge sysclk);
    if (auto_chk) compare_all("rand");
  endtask

  // Reset, pulse modeControl, and return just after the edge that enters RUN.
  task automatic start_run(input logic [1:0] tm);
    testmode = tm;
    resetb = 1'b0;
    cycle();
    resetb = 1'b1;
    modeControl = 1'b1;
    cycle();
    modeControl = 1'b0;
    cycle();
    cycle();
    check("run_entry", {31'd0, running}, 32'd1);
  endtask

  typedef struct {
    logic [1:0] tm;
    int         n;
    int         exp_val;
    bit         exp_lit;
  } vec_t;

  vec_t vecs[7];

  initial begin
    resetb = 1'b0; testmode = 2'b10;
    modeControl = 1'b0; clearControl = 1'b0; lapControl = 1'b0;
    @(negedge sysclk);

    cycle();
    resetb = 1'b1;
    check("reset_hex", {4'h0, hex}, {4'h0, enc(0)});
    check("reset_running", {31'd0, running}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);

    // n = RUN cycles after entry; hex is read one cycle later.
    vecs[0] = '{tm: 2'b10, n: 12, exp_val: 12, exp_lit: 1'b0};
    vecs[1] = '{tm: 2'b00, n: 19, exp_val: 0,  exp_lit: 1'b0};
    vecs[2] = '{tm: 2'b00, n: 20, exp_val: 1,  exp_lit: 1'b0};
    vecs[3] = '{tm: 2'b01, n: 1,  exp_val: 0,  exp_lit: 1'b0};
    vecs[4] = '{tm: 2'b01, n: 2,  exp_val: 1,  exp_lit: 1'b0};
    vecs[5] = '{tm: 2'b01, n: 6,  exp_val: 3,  exp_lit: 1'b0};
    vecs[6] = '{tm: 2'b11, n: 5,  exp_val: 0,  exp_lit: 1'b1};
    for (int v = 0; v < 7; v++) begin
      start_run(vecs[v].tm);
      repeat (vecs[v].n + 1) cycle();
      check($sformatf("vec%0d_hex", v), {4'h0, hex},
            {4'h0, vecs[v].exp_lit ? 28'h0 : enc(vecs[v].exp_val)});
      check($sformatf("vec%0d_running", v), {31'd0, running}, 32'd1);
      compare_all($sformatf("vec%0d_model", v));
    end

    // Wrap from 9999 to 0000 sets the sticky overflow; clear drops it.
    start_run(2'b10);
    repeat (10000) cycle();
    check("wrap_hex9999", {4'h0, hex}, {4'h0, enc(9999)});
    check("wrap_overflow", {31'd0, overflow}, 32'd1);
    cycle();
    check("wrap_hex0000", {4'h0, hex}, {4'h0, enc(0)});
    repeat (5) cycle();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clearControl = 1'b1; cycle(); clearControl = 1'b0; cycle(); cycle();
    check("clear_running", {31'd0, running}, 32'd0);
    check("clear_overflow", {31'd0, overflow}, 32'd0);
    cycle();
    check("clear_hex", {4'h0, hex}, {4'h0, enc(0)});

    // Pause holds count and prescaler; resume ticks on the first RUN edge.
    start_run(2'b01);
    repeat (6) cycle();
    modeControl = 1'b1; cycle(); modeControl = 1'b0; cycle(); cycle();
    check("pause_running", {31'd0, running}, 32'd0);
    repeat (100) cycle();
    check("pause_hold_hex", {4'h0, hex}, {4'h0, enc(4)});
    modeControl = 1'b1; cycle(); modeControl = 1'b0; cycle(); cycle();
    check("resume_running", {31'd0, running}, 32'd1);
    cycle();
    check("resume_hex4", {4'h0, hex}, {4'h0, enc(4)});
    cycle();
    check("resume_hex5", {4'h0, hex}, {4'h0, enc(5)});
    compare_all("resume_model");

    // Mode and clear together: clear wins.
    start_run(2'b10);
    repeat (10) cycle();
    modeControl = 1'b1; clearControl = 1'b1; cycle();
    modeControl = 1'b0; clearControl = 1'b0; cycle(); cycle();
    check("both_running", {31'd0, running}, 32'd0);
    repeat (5) cycle();
    check("both_hex", {4'h0, hex}, {4'h0, enc(0)});

    // Synchronous reset in the middle of RUN.
    start_run(2'b10);
    repeat (20) cycle();
    resetb = 1'b0; cycle(); resetb = 1'b1;
    check("midrst_hex", {4'h0, hex}, {4'h0, enc(0)});
    check("midrst_running", {31'd0, running}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);

`ifdef STOPWATCH_LAP_HOLD_EN
    start_run(2'b10);
    repeat (38) cycle();
    lapControl = 1'b1; cycle(); lapControl = 1'b0; cycle(); cycle();
    cycle();
    check("lap_freeze40", {4'h0, hex}, {4'h0, enc(40)});
    repeat (19) cycle();
    check("lap_hold40", {4'h0, hex}, {4'h0, enc(40)});
    lapControl = 1'b1; cycle(); lapControl = 1'b0; cycle(); cycle();
    cycle();
    check("lap_release", {4'h0, hex}, {4'h0, enc(64)});
`endif

    // Random phase: every cycle compared with the model.
    start_run(2'b10);
    auto_chk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) modeControl = ~modeControl;
      if ($urandom_range(0, 99) < 1) clearControl = ~clearControl;
      if ($urandom_range(0, 99) < 4) lapControl = ~lapControl;
      if ($urandom_range(0, 199) == 0) testmode = 2'($urandom_range(0, 3));
      resetb = ($urandom_range(0, 999) != 0);
      cycle();
    end
    auto_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_n.md
STOPWATCH_DISPLAY_N -- requirements
Module: stopwatch_display_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD digits counted and displayed (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 500000, sysclk cycles per count tick in normal mode (>=10).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning a lit segment is driven 0.
REQ-004 SHALL have port sysclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port resetb  input  1  synchronous, active-low reset.
REQ-006 SHALL have port testmode  input  2  tick-rate/display mode select.
REQ-007 SHALL have port modeControl  input  1  asynchronous start/pause button.
REQ-008 SHALL have port clearControl  input  1  asynchronous clear button.
REQ-009 SHALL have port lapControl  input  1  asynchronous lap button.
REQ-010 SHALL have port hex  output  7*NUM_DIGITS  seven-segment codes; digit k at bits [7k+6:7k], bit 0=a .. bit 6=g, digit 0 least significant.
REQ-011 SHALL have port running  output  1  high in RUN state.
REQ-012 SHALL have port overflow  output  1  sticky wrap flag.

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser plus edge-detect flop; one rising edge yields exactly one event pulse, acted on at the 3rd sysclk edge sampling the input high.
REQ-014 SHALL implement FSM IDLE/RUN/PAUSE: mode event IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-015 SHALL, on clear event in any state: enter IDLE, zero digits and prescaler, clear overflow, release lap freeze; clear wins over a simultaneous mode or lap event.
REQ-016 SHALL run a prescaler only in RUN: counts 0..DIV-1, tick on the edge where it wraps DIV-1 -> 0; value held in PAUSE, zeroed in IDLE.
REQ-017 SHALL set DIV by testmode: 00 = CLK_DIV, 01 = CLK_DIV/10 (integer), 10 = 1 (tick every RUN cycle), 11 = CLK_DIV.
REQ-018 SHALL zero the prescaler on the edge following any testmode change.
REQ-019 SHALL increment the BCD digit chain by one on each tick, digit updating on the same edge as the tick, carry rippling within that cycle; no digit ever exceeds 9.
REQ-020 SHALL, on tick with all digits 9, wrap all to 0 and set overflow; overflow stays 1 until clear or reset; counting continues.
REQ-021 SHALL encode digits (active-low, g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; SEG_ACTIVE_LOW=0 inverts all bits.
REQ-022 SHALL, in testmode 11, drive all segments lit on every digit without affecting counting.
REQ-023 SHALL register hex: display reflects digit value one cycle after digit update.

Reset
REQ-024 SHALL, while resetb=0 at a sysclk edge: state IDLE, digits 0, prescaler 0, synchroniser/edge flops 0, lap freeze off, overflow=0, running=0.
REQ-025 SHALL drive hex to encoded "0" on every digit on the edge after reset is sampled, including reset mid-RUN.

Configuration
REQ-026 SHALL, with macro STOPWATCH_LAP_HOLD_EN defined, toggle a lap freeze on each lap event in RUN: freeze latches current digits into hex and holds it while counting continues; second lap event releases to live digits; lap events in IDLE/PAUSE ignored.
REQ-027 SHALL, without STOPWATCH_LAP_HOLD_EN, keep lapControl port present but ignored, with no lap registers synthesised.

Verification (NUM_DIGITS=4, CLK_DIV=20, SEG_ACTIVE_LOW=1)
REQ-028 SHALL cover: reset, testmode=10, pulse modeControl, run 12 RUN cycles -> digits 0012, hex[6:0]=0100100, hex[13:7]=1111001, running=1.
REQ-029 SHALL cover: testmode=00 from RUN start -> first increment exactly 20 cycles after RUN entry; testmode=01 -> every 2 cycles.
REQ-030 SHALL cover: testmode=10, preload via 9999 ticks, one more tick -> digits 0000, overflow=1; clearControl pulse -> IDLE, overflow=0.
REQ-031 SHALL cover: mode pulse in RUN -> PAUSE, digits and prescaler frozen 100 cycles; mode pulse -> resumes from held prescaler value.
REQ-032 SHALL cover: mode and clear rising same cycle during RUN -> IDLE, digits 0000; resetb=0 mid-RUN -> all outputs at reset values next edge.
REQ-033 SHALL cover (macro defined): lap pulse at 0040 -> hex shows 0040 while digits advance to 0060; second lap pulse -> hex shows live value.
